dec_trace_capture: RTL

- Consumer-side counterpart of the emulator control generator. It takes the `emu_dec_thr` decimation threshold and uses it to down-sample an emulator probe bus into a trace FIFO.
- A host-side reader drains the FIFO through a valid/ready handshake.
- It sits between the emulator core probes and the debug readout path (ILA/host bridge), all on `emu_clk`.

---
 rtl/dec_trace_capture.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dec_trace_capture.sv
// Decimating trace capture: down-samples a probe bus into a first-word-fall-through FIFO
// that a host-side reader drains through a valid/ready handshake.
module dec_trace_capture #(
  parameter int unsigned dec_bits  = 1,
  parameter int unsigned data_bits = 16,
  parameter int unsigned addr_bits = 4,
  parameter int unsigned len_bits  = 16
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst_n,
  input  logic [dec_bits-1:0]  emu_dec_thr,
  input  logic                 arm,
  input  logic [len_bits-1:0]  capture_len,
  input  logic [data_bits-1:0] probe_in,
  output logic [data_bits-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 busy,
  output logic                 done,
  output logic [len_bits-1:0]  overflow_cnt
);

  localparam int unsigned Depth = 2 ** addr_bits;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [dec_bits-1:0]  dec_cnt_q, dec_cnt_d;
  logic [len_bits-1:0]  smp_cnt_q, smp_cnt_d;
  logic [len_bits-1:0]  len_q, len_d;
  logic [len_bits-1:0]  ovf_q, ovf_d;
  logic [addr_bits:0]   wptr_q, wptr_d;
  logic [addr_bits:0]   rptr_q, rptr_d;
  logic [data_bits-1:0] mem_q [Depth];

  logic arm_ok;
  logic strobe;
  logic last_smp;
  logic empty;
  logic full;
  logic pop;
  logic push;

  // Arm is only meaningful outside CAPTURE; DONE re-arms exactly like IDLE.
  assign arm_ok   = arm && (state_q != StCapture);
  // >= rather than == so a threshold lowered mid-count strobes on the very next cycle.
  assign strobe   = (state_q == StCapture) && (dec_cnt_q >= emu_dec_thr);
  assign last_smp = strobe && ((smp_cnt_q + len_bits'(1)) == len_q);

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[addr_bits] != rptr_q[addr_bits]) &&
                 (wptr_q[addr_bits-1:0] == rptr_q[addr_bits-1:0]);
  assign pop   = !empty && rd_ready;
  assign push  = strobe && (!full || pop);

  // State register
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d = (capture_len == '0) ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (last_smp) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    busy         = (state_q == StCapture);
    done         = (state_q == StDone);
    rd_valid     = !empty;
    rd_data      = empty ? '0 : mem_q[rptr_q[addr_bits-1:0]];
    overflow_cnt = ovf_q;
  end

  // Capture counters
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    smp_cnt_d = smp_cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    if (arm_ok) begin
      len_d     = capture_len;
      dec_cnt_d = '0;
      smp_cnt_d = '0;
      ovf_d     = '0;
    end else if (state_q == StCapture) begin
      dec_cnt_d = strobe ? '0 : dec_cnt_q + dec_bits'(1);
      if (strobe) begin
        // A dropped sample still advances the sample count.
        smp_cnt_d = smp_cnt_q + len_bits'(1);
        if (!push && (ovf_q != '1)) begin
          ovf_d = ovf_q + len_bits'(1);
        end
      end
    end
  end

  // FIFO pointers
  always_comb begin
    wptr_d = push ? wptr_q + (addr_bits + 1)'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + (addr_bits + 1)'(1) : rptr_q;
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      dec_cnt_q <= '0;
      smp_cnt_q <= '0;
      len_q     <= '0;
      ovf_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge emu_clk) begin
    if (push) begin
      mem_q[wptr_q[addr_bits-1:0]] <= probe_in;
    end
  end

endmodule
